order_book_engine: RTL
======================

// Module: order_book_engine
// PURPOSE
// - Parametrised limit order book and matcher: resting bid/ask tables of DEPTH entries each.
// - Matches with price-time priority, continues partial fills across several resting orders,
//   and rests the residual. Supports cancel-by-id and reports per-command completion status.
// - Sits downstream of the packet/payload decoder and upstream of the trade reporting path.
// PARAMETERS
// - DEPTH    16  resting entries per side (>=2); IDX_W = $clog2(DEPTH)
// - PRICE_W   8  price width, unsigned
// - QTY_W     8  quantity width, unsigned
// - ID_W      8  order id width
// - SEQ_W     8  age-stamp width; must satisfy 2**(SEQ_W-1) > 2*DEPTH
// PORTS
// - CLK          in   1        clock, rising edge
// - RESET_N      in   1        asynchronous active-low reset
// - cmd_valid    in   1        command present
// - cmd_ready    out  1        engine accepts a command (high only in IDLE)
// - cmd_cancel   in   1        1 = cancel order cmd_id on side cmd_side
// - cmd_side     in   1        0 = buy, 1 = sell
// - cmd_ioc      in   1        immediate-or-cancel (used only with IOC_ORDER_EN)
// - cmd_price    in   PRICE_W  limit price
// - cmd_qty      in   QTY_W    order quantity
// - cmd_id       in   ID_W     order id
// - trade_valid  out  1        trade record held until accepted
// - trade_ready  in   1        downstream accepts trade
// - trade_price  out  PRICE_W  execution price (resting order's price)
// - trade_qty    out  QTY_W    executed quantity
// - buy_id       out  ID_W     buyer order id
// - sell_id      out  ID_W     seller order id
// - done_valid   out  1        one-cycle pulse: command finished
// - done_code    out  3        0 RESTED, 1 FILLED, 2 CANCELLED, 3 CANCEL_MISS,
//                              4 REJECT (book full or qty 0), 5 IOC_KILLED
// - bid_count    out  IDX_W+1  valid bid entries
// - ask_count    out  IDX_W+1  valid ask entries
// BEHAVIOUR
// - Reset (RESET_N low, async): all entry valids 0, counts 0, state IDLE, age counter 0,
//   trade_valid/done_valid 0, trade/id fields 0, done_code 0. cmd_ready low in reset, 1 in IDLE.
// - Accept on cmd_valid && cmd_ready; all cmd_* fields are captured; input is ignored until IDLE.
// - States: IDLE, SEARCH, TRADE, INSERT, CANCEL, DONE.
// - IDLE: accept. Cancel -> CANCEL. qty==0 -> DONE(REJECT). Else -> SEARCH with idx=0.
// - SEARCH: one opposite-side entry per cycle (DEPTH cycles). Eligible: buy if ask_p<=price,
//   sell if bid_p>=price. Best = lowest ask / highest bid; tie -> older stamp, compared
//   wrap-safe: a older than b iff MSB of (a-b) is 1. After the last index: candidate -> TRADE;
//   none -> INSERT (IOC handling under CONFIGURATION).
// - TRADE: trade_valid=1, fill=min(rem,resting_q); fields held stable until trade_ready.
//   On handshake: resting_q -= fill (entry invalidated at 0), rem -= fill; rem==0 -> DONE(FILLED),
//   else -> SEARCH restarts from idx 0. Minimum latency of the first trade = DEPTH+1 cycles
//   after accept.
// - INSERT: lowest-index free entry on own side, written in 1 cycle, stamp=age counter,
//   counter+1 (wraps). -> DONE(RESTED). No free entry -> DONE(REJECT), residual dropped,
//   earlier trades stand.
// - CANCEL: scan own side from idx 0, one entry per cycle; first valid id match is invalidated
//   -> DONE(CANCELLED); no match after DEPTH -> DONE(CANCEL_MISS). Duplicate ids are permitted;
//   only the lowest index is cancelled.
// - DONE: done_valid pulse 1 cycle, -> IDLE. Counts update in the cycle the valid bit changes.
// - Arithmetic is unsigned QTY_W; fill<=rem and fill<=resting_q, so no underflow occurs.
// - Asserting RESET_N low mid-command aborts it; a pending trade is dropped with no done pulse.
// CONFIGURATION
// - IOC_ORDER_EN defined: cmd_ioc=1 orders never rest; SEARCH finding no candidate with
//   rem>0 -> DONE(IOC_KILLED), with code 5 even when partially filled.
// - IOC_ORDER_EN undefined: cmd_ioc ignored; all orders rest residual; code 5 never emitted.
// TESTING
// - Rest sell p=100 q=10 id=1; buy p=99 q=5 id=2 -> no trade, done RESTED, bid_count=1 ask_count=1.
// - Asks p=101 id=3 (first), p=100 id=4, p=100 id=5; buy p=102 q=4 -> trade p=100 q=4 sell_id=4.
// - Asks p=100 q=3, p=101 q=3; buy p=101 q=10 id=9 -> trades q=3@100 then q=3@101,
//   bid rests q=4, done RESTED.
// - Hold trade_ready=0 for 5 cycles -> trade fields stable, trade_valid high, cmd_ready low.
// - Fill all DEPTH bid entries, then send buy no-match -> REJECT; cancel id absent -> CANCEL_MISS;
//   cancel resting id -> CANCELLED, bid_count-1.
// - IOC_ORDER_EN: ask q=2 p=50; IOC buy p=50 q=5 -> trade q=2, done IOC_KILLED, bid_count=0.

Source files
------------

// File: rtl/order_book_engine_if.sv
// Command / trade / completion bus of the order book engine.
interface order_book_engine_if #(
  parameter int PRICE_W = 8,
  parameter int QTY_W   = 8,
  parameter int ID_W    = 8,
  parameter int CNT_W   = 5
);
  logic               cmd_valid;
  logic               cmd_ready;
  logic               cmd_cancel;
  logic               cmd_side;
  logic               cmd_ioc;
  logic [PRICE_W-1:0] cmd_price;
  logic [QTY_W-1:0]   cmd_qty;
  logic [ID_W-1:0]    cmd_id;
  logic               trade_valid;
  logic               trade_ready;
  logic [PRICE_W-1:0] trade_price;
  logic [QTY_W-1:0]   trade_qty;
  logic [ID_W-1:0]    buy_id;
  logic [ID_W-1:0]    sell_id;
  logic               done_valid;
  logic [2:0]         done_code;
  logic [CNT_W-1:0]   bid_count;
  logic [CNT_W-1:0]   ask_count;

  modport master (
    output cmd_valid, cmd_cancel, cmd_side, cmd_ioc, cmd_price, cmd_qty, cmd_id, trade_ready,
    input  cmd_ready, trade_valid, trade_price, trade_qty, buy_id, sell_id,
           done_valid, done_code, bid_count, ask_count
  );
  modport slave (
    input  cmd_valid, cmd_cancel, cmd_side, cmd_ioc, cmd_price, cmd_qty, cmd_id, trade_ready,
    output cmd_ready, trade_valid, trade_price, trade_qty, buy_id, sell_id,
           done_valid, done_code, bid_count, ask_count
  );
endinterface

// File: rtl/order_book_engine.sv
// Limit order book with price-time matching, partial fills, resting and cancel-by-id.
// Optional feature macro: IOC_ORDER_EN (immediate-or-cancel orders never rest).
module order_book_engine #(
  parameter int DEPTH   = 16,
  parameter int PRICE_W = 8,
  parameter int QTY_W   = 8,
  parameter int ID_W    = 8,
  parameter int SEQ_W   = 8
) (
  input logic CLK,
  input logic RESET_N,
  order_book_engine_if.slave ifc
);
  localparam int IDX_W = $clog2(DEPTH);

  typedef struct packed {
    logic               vld;
    logic [PRICE_W-1:0] price;
    logic [QTY_W-1:0]   qty;
    logic [ID_W-1:0]    id;
    logic [SEQ_W-1:0]   stamp;
  } entry_t;

  typedef enum logic [2:0] {S_IDLE, S_SEARCH, S_TRADE, S_INSERT, S_CANCEL, S_DONE} state_t;

  localparam logic [2:0] RC_RESTED = 3'd0, RC_FILLED = 3'd1, RC_CANCELLED = 3'd2,
                         RC_MISS   = 3'd3, RC_REJECT = 3'd4;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               side_q, side_d;
  logic [PRICE_W-1:0] price_q, price_d;
  logic [QTY_W-1:0]   rem_q, rem_d;
  logic [ID_W-1:0]    id_q, id_d;
  logic               cand_vld_q, cand_vld_d;
  logic [IDX_W-1:0]   cand_idx_q, cand_idx_d;
  logic [PRICE_W-1:0] cand_price_q, cand_price_d;
  logic [QTY_W-1:0]   cand_qty_q, cand_qty_d;
  logic [ID_W-1:0]    cand_id_q, cand_id_d;
  logic [SEQ_W-1:0]   cand_stamp_q, cand_stamp_d;
  logic [SEQ_W-1:0]   age_q, age_d;
  logic               tr_vld_q, tr_vld_d;
  logic [PRICE_W-1:0] tr_price_q, tr_price_d;
  logic [QTY_W-1:0]   tr_qty_q, tr_qty_d;
  logic [ID_W-1:0]    tr_buy_q, tr_buy_d;
  logic [ID_W-1:0]    tr_sell_q, tr_sell_d;
  logic               done_vld_q, done_vld_d;
  logic [2:0]         done_code_q, done_code_d;
  entry_t             bid_q [DEPTH];
  entry_t             bid_d [DEPTH];
  entry_t             ask_q [DEPTH];
  entry_t             ask_d [DEPTH];

`ifdef IOC_ORDER_EN
  logic ioc_q, ioc_d;
`else
  logic unused_ioc;
  assign unused_ioc = ifc.cmd_ioc;
`endif

  // Entry under the scan pointer on the opposite side (matching) and own side (cancel)
  entry_t           opp_e, own_e;
  logic             eligible, better_price, older, take, last;
  logic [SEQ_W-1:0] stamp_diff;
  logic             fin_vld;
  logic [PRICE_W-1:0] fin_price;
  logic [QTY_W-1:0] fin_qty, fill;
  logic [ID_W-1:0]  fin_id;
  logic             free_found;
  logic [IDX_W-1:0] free_idx;
  logic [IDX_W:0]   bid_cnt, ask_cnt;

  assign opp_e = side_q ? bid_q[idx_q] : ask_q[idx_q];
  assign own_e = side_q ? ask_q[idx_q] : bid_q[idx_q];

  always_comb begin
    eligible     = opp_e.vld && (side_q ? (opp_e.price >= price_q) : (opp_e.price <= price_q));
    better_price = side_q ? (opp_e.price > cand_price_q) : (opp_e.price < cand_price_q);
    stamp_diff   = opp_e.stamp - cand_stamp_q;
    older        = stamp_diff[SEQ_W-1];
    take         = eligible && (!cand_vld_q || better_price ||
                                ((opp_e.price == cand_price_q) && older));
    last         = (idx_q == IDX_W'(DEPTH-1));
    fin_vld      = take || cand_vld_q;
    fin_price    = take ? opp_e.price : cand_price_q;
    fin_qty      = take ? opp_e.qty   : cand_qty_q;
    fin_id       = take ? opp_e.id    : cand_id_q;
    fill         = (rem_q < fin_qty) ? rem_q : fin_qty;
  end

  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    bid_cnt    = '0;
    ask_cnt    = '0;
    for (int i = DEPTH-1; i >= 0; i--) begin
      if (!(side_q ? ask_q[i].vld : bid_q[i].vld)) begin
        free_found = 1'b1;
        free_idx   = IDX_W'(i);
      end
      bid_cnt = bid_cnt + (IDX_W+1)'(bid_q[i].vld);
      ask_cnt = ask_cnt + (IDX_W+1)'(ask_q[i].vld);
    end
  end

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    side_d       = side_q;
    price_d      = price_q;
    rem_d        = rem_q;
    id_d         = id_q;
    cand_vld_d   = cand_vld_q;
    cand_idx_d   = cand_idx_q;
    cand_price_d = cand_price_q;
    cand_qty_d   = cand_qty_q;
    cand_id_d    = cand_id_q;
    cand_stamp_d = cand_stamp_q;
    age_d        = age_q;
    tr_vld_d     = tr_vld_q;
    tr_price_d   = tr_price_q;
    tr_qty_d     = tr_qty_q;
    tr_buy_d     = tr_buy_q;
    tr_sell_d    = tr_sell_q;
    done_code_d  = done_code_q;
    bid_d        = bid_q;
    ask_d        = ask_q;
`ifdef IOC_ORDER_EN
    ioc_d        = ioc_q;
`endif
    unique case (state_q)
      S_IDLE: if (ifc.cmd_valid) begin
        side_d     = ifc.cmd_side;
        price_d    = ifc.cmd_price;
        rem_d      = ifc.cmd_qty;
        id_d       = ifc.cmd_id;
        idx_d      = '0;
        cand_vld_d = 1'b0;
`ifdef IOC_ORDER_EN
        ioc_d      = ifc.cmd_ioc;
`endif
        if (ifc.cmd_cancel) state_d = S_CANCEL;
        else if (ifc.cmd_qty == '0) begin
          state_d     = S_DONE;
          done_code_d = RC_REJECT;
        end else state_d = S_SEARCH;
      end
      S_SEARCH: begin
        if (take) begin
          cand_vld_d   = 1'b1;
          cand_idx_d   = idx_q;
          cand_price_d = opp_e.price;
          cand_qty_d   = opp_e.qty;
          cand_id_d    = opp_e.id;
          cand_stamp_d = opp_e.stamp;
        end
        if (!last) idx_d = idx_q + IDX_W'(1);
        else if (fin_vld) begin
          state_d    = S_TRADE;
          tr_vld_d   = 1'b1;
          tr_price_d = fin_price;
          tr_qty_d   = fill;
          tr_buy_d   = side_q ? fin_id : id_q;
          tr_sell_d  = side_q ? id_q : fin_id;
        end
`ifdef IOC_ORDER_EN
        else if (ioc_q) begin
          state_d     = S_DONE;
          done_code_d = 3'd5;
        end
`endif
        else state_d = S_INSERT;
      end
      S_TRADE: if (ifc.trade_ready) begin
        tr_vld_d = 1'b0;
        if (side_q) begin
          bid_d[cand_idx_q].qty = bid_q[cand_idx_q].qty - tr_qty_q;
          if (bid_q[cand_idx_q].qty == tr_qty_q) bid_d[cand_idx_q].vld = 1'b0;
        end else begin
          ask_d[cand_idx_q].qty = ask_q[cand_idx_q].qty - tr_qty_q;
          if (ask_q[cand_idx_q].qty == tr_qty_q) ask_d[cand_idx_q].vld = 1'b0;
        end
        rem_d = rem_q - tr_qty_q;
        if (rem_q == tr_qty_q) begin
          state_d     = S_DONE;
          done_code_d = RC_FILLED;
        end else begin
          state_d    = S_SEARCH;
          idx_d      = '0;
          cand_vld_d = 1'b0;
        end
      end
      S_INSERT: begin
        state_d = S_DONE;
        if (free_found) begin
          if (side_q) ask_d[free_idx] = '{1'b1, price_q, rem_q, id_q, age_q};
          else        bid_d[free_idx] = '{1'b1, price_q, rem_q, id_q, age_q};
          age_d       = age_q + SEQ_W'(1);
          done_code_d = RC_RESTED;
        end else done_code_d = RC_REJECT;
      end
      S_CANCEL: begin
        if (own_e.vld && (own_e.id == id_q)) begin
          if (side_q) ask_d[idx_q].vld = 1'b0;
          else        bid_d[idx_q].vld = 1'b0;
          state_d     = S_DONE;
          done_code_d = RC_CANCELLED;
        end else if (last) begin
          state_d     = S_DONE;
          done_code_d = RC_MISS;
        end else idx_d = idx_q + IDX_W'(1);
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    done_vld_d = (state_d == S_DONE);
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q      <= S_IDLE;
      idx_q        <= '0;
      side_q       <= 1'b0;
      price_q      <= '0;
      rem_q        <= '0;
      id_q         <= '0;
      cand_vld_q   <= 1'b0;
      cand_idx_q   <= '0;
      cand_price_q <= '0;
      cand_qty_q   <= '0;
      cand_id_q    <= '0;
      cand_stamp_q <= '0;
      age_q        <= '0;
      tr_vld_q     <= 1'b0;
      tr_price_q   <= '0;
      tr_qty_q     <= '0;
      tr_buy_q     <= '0;
      tr_sell_q    <= '0;
      done_vld_q   <= 1'b0;
      done_code_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        bid_q[i] <= '0;
        ask_q[i] <= '0;
      end
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      side_q       <= side_d;
      price_q      <= price_d;
      rem_q        <= rem_d;
      id_q         <= id_d;
      cand_vld_q   <= cand_vld_d;
      cand_idx_q   <= cand_idx_d;
      cand_price_q <= cand_price_d;
      cand_qty_q   <= cand_qty_d;
      cand_id_q    <= cand_id_d;
      cand_stamp_q <= cand_stamp_d;
      age_q        <= age_d;
      tr_vld_q     <= tr_vld_d;
      tr_price_q   <= tr_price_d;
      tr_qty_q     <= tr_qty_d;
      tr_buy_q     <= tr_buy_d;
      tr_sell_q    <= tr_sell_d;
      done_vld_q   <= done_vld_d;
      done_code_q  <= done_code_d;
      bid_q        <= bid_d;
      ask_q        <= ask_d;
    end
  end

`ifdef IOC_ORDER_EN
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) ioc_q <= 1'b0;
    else          ioc_q <= ioc_d;
  end
`endif

  assign ifc.cmd_ready   = (state_q == S_IDLE) && RESET_N;
  assign ifc.trade_valid = tr_vld_q;
  assign ifc.trade_price = tr_price_q;
  assign ifc.trade_qty   = tr_qty_q;
  assign ifc.buy_id      = tr_buy_q;
  assign ifc.sell_id     = tr_sell_q;
  assign ifc.done_valid  = done_vld_q;
  assign ifc.done_code   = done_code_q;
  assign ifc.bid_count   = bid_cnt;
  assign ifc.ask_count   = ask_cnt;
endmodule
